// File: rtl/pin_channel_ctrl_if.sv
// Register bus for pin_channel_ctrl: address, write strobe, write data and registered read data.
interface pin_channel_ctrl_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output addr, output wr_en, output data_in, input data_out);
    modport slave  (input addr, input wr_en, input data_in, output data_out);
endinterface

// File: rtl/pin_channel_ctrl.sv
// One pin channel: register-mapped PWM / constant / sampling pin driver with IDLE-HIGH-LOW run FSM.
// Optional macro PINCTRL_SAMPLE_EN enables mode 3 (pin sampling into SAMPLE); without it mode 3 acts as OFF.
module pin_channel_ctrl #(
    parameter int POSITION = 1,
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pin_channel_ctrl_if.slave    bus,
    input  logic                 pin_in,
    output logic                 pin_output,
    output logic                 pin_oe,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;

    localparam logic [1:0] M_PWM = 2'd1, M_CONST = 2'd2, M_SAMPLE = 2'd3;
    localparam logic [ADDR_W-1:0] A_GCMD   = '0;
    localparam logic [ADDR_W-1:0] A_DUTY   = ADDR_W'(POSITION);
    localparam logic [ADDR_W-1:0] A_ANTI   = ADDR_W'(POSITION + 1);
    localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(POSITION + 2);
    localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(POSITION + 3);
    localparam logic [ADDR_W-1:0] A_LCMD   = ADDR_W'(POSITION + 4);
    localparam logic [ADDR_W-1:0] A_SAMPLE = ADDR_W'(POSITION + 5);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   duty_q, duty_d, anti_q, anti_d, cycles_q, cycles_d;
    logic [3:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   duty_cnt_q, duty_cnt_d, anti_cnt_q, anti_cnt_d, cyc_cnt_q, cyc_cnt_d;
    logic               run_inf_q, run_inf_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               sample_tick, period_end, cmd_hit, start, stop, mode_run;

`ifdef PINCTRL_SAMPLE_EN
    localparam bit SAMPLE_EN = 1'b1;
    logic [DATA_W-1:0] sample_q, sample_d;

    // Capture happens on the last HIGH cycle of each period.
    always_comb begin
        sample_d = sample_q;
        if (sample_tick && mode_q[1:0] == M_SAMPLE)
            sample_d = {sample_q[DATA_W-2:0], pin_in};
    end

    always_ff @(posedge clk) begin
        if (reset) sample_q <= '0;
        else       sample_q <= sample_d;
    end
`else
    localparam bit SAMPLE_EN = 1'b0;
    logic [DATA_W-1:0] sample_q;
    logic              unused_sample;
    assign sample_q      = '0;
    assign unused_sample = ^{pin_in, sample_tick};
`endif

    assign cmd_hit  = bus.wr_en && (bus.addr == A_GCMD || bus.addr == A_LCMD);
    assign stop     = cmd_hit && bus.data_in == DATA_W'(2);
    assign start    = cmd_hit && bus.data_in == DATA_W'(1) && !stop;
    assign mode_run = (mode_q[1:0] == M_PWM) || (SAMPLE_EN && mode_q[1:0] == M_SAMPLE);

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        anti_d      = anti_q;
        cycles_d    = cycles_q;
        mode_d      = mode_q;
        duty_cnt_d  = duty_cnt_q;
        anti_cnt_d  = anti_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        run_inf_d   = run_inf_q;
        done_d      = 1'b0;
        sample_tick = 1'b0;
        period_end  = 1'b0;

        if (bus.wr_en && bus.addr == A_DUTY)   duty_d   = bus.data_in[CNT_W-1:0];
        if (bus.wr_en && bus.addr == A_ANTI)   anti_d   = bus.data_in[CNT_W-1:0];
        if (bus.wr_en && bus.addr == A_CYCLES) cycles_d = bus.data_in[CNT_W-1:0];
        if (bus.wr_en && bus.addr == A_MODE)   mode_d   = bus.data_in[3:0];

        case (state_q)
            IDLE: if (start && mode_run) begin
                if ((cycles_q == '0 && !mode_q[3]) || (duty_q == '0 && anti_q == '0)) begin
                    done_d = 1'b1;
                end else begin
                    duty_cnt_d = duty_q;
                    anti_cnt_d = anti_q;
                    cyc_cnt_d  = cycles_q;
                    run_inf_d  = mode_q[3];
                    state_d    = (duty_q != '0) ? HIGH : LOW;
                end
            end
            HIGH: if (duty_cnt_q <= CNT_W'(1)) begin
                duty_cnt_d  = '0;
                sample_tick = 1'b1;
                if (anti_cnt_q != '0) state_d = LOW;
                else                  period_end = 1'b1;
            end else begin
                duty_cnt_d = duty_cnt_q - CNT_W'(1);
            end
            LOW: if (anti_cnt_q <= CNT_W'(1)) begin
                anti_cnt_d = '0;
                period_end = 1'b1;
            end else begin
                anti_cnt_d = anti_cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Period reload is the only point where mid-run DUTY/ANTI writes take effect.
        if (period_end) begin
            if (!run_inf_q && cyc_cnt_q <= CNT_W'(1)) begin
                cyc_cnt_d = '0;
                state_d   = IDLE;
                done_d    = 1'b1;
            end else begin
                if (!run_inf_q) cyc_cnt_d = cyc_cnt_q - CNT_W'(1);
                duty_cnt_d = duty_q;
                anti_cnt_d = anti_q;
                if (duty_q != '0)      state_d = HIGH;
                else if (anti_q != '0) state_d = LOW;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        if (stop && state_q != IDLE) begin
            state_d    = IDLE;
            duty_cnt_d = '0;
            anti_cnt_d = '0;
            cyc_cnt_d  = '0;
            done_d     = 1'b1;
        end
    end

    always_comb begin
        data_out_d = '0;
        if      (bus.addr == A_DUTY)   data_out_d = DATA_W'(duty_q);
        else if (bus.addr == A_ANTI)   data_out_d = DATA_W'(anti_q);
        else if (bus.addr == A_CYCLES) data_out_d = DATA_W'(cycles_q);
        else if (bus.addr == A_MODE)   data_out_d = DATA_W'(mode_q);
        else if (bus.addr == A_SAMPLE) data_out_d = sample_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            anti_q     <= '0;
            cycles_q   <= '0;
            mode_q     <= '0;
            duty_cnt_q <= '0;
            anti_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            run_inf_q  <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            anti_q     <= anti_d;
            cycles_q   <= cycles_d;
            mode_q     <= mode_d;
            duty_cnt_q <= duty_cnt_d;
            anti_cnt_q <= anti_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            run_inf_q  <= run_inf_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign pin_oe       = (mode_q[1:0] == M_PWM) || (mode_q[1:0] == M_CONST);
    assign pin_output   = (mode_q[1:0] == M_PWM && state_q == HIGH) ||
                          (mode_q[1:0] == M_CONST && mode_q[2]);
endmodule
